serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - bin.
// Ports: a, b, bin (inputs); diff, bout (difference and borrow out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, one bit/cycle.
// Ports: clk, rst_n (async, active-low), start, a, b -> diff, borrow_out,
// busy, done. Macro SERIAL_SUB_SAT_EN: saturate diff to 0 on underflow.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             br_bit;
    logic [WIDTH-1:0] final_diff;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (d_bit),
        .bout (br_bit)
    );

    // Final diff as presented on leaving DONE.
`ifdef SERIAL_SUB_SAT_EN
    assign final_diff = br ? '0 : res_sr;
`else
    assign final_diff = res_sr;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        cnt  <= '0;
                        br   <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Result fills from the MSB end so after WIDTH
                    // shifts bit 0 lands in res_sr[0].
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_bit;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    diff       <= final_diff;
                    borrow_out <= br;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Each task drives one scenario and checks results inline.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation; done must rise 9 edges after the accept edge.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb,
                         input string name);
        int seen;
        int lat;
        seen = 0;
        lat  = 0;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b want 1", name, busy);
        end
        for (int n = 1; n <= W + 6; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (seen == 0) lat = n;
                seen++;
            end
        end
        checks++;
        if (seen != 1 || lat != W + 1) begin
            errors++;
            $display("FAIL %s_done: pulses %0d at edge %0d want 1 at %0d",
                     name, seen, lat, W + 1);
        end
        checks++;
        if (diff !== ed) begin
            errors++;
            $display("FAIL %s_diff: got %0d want %0d", name, diff, ed);
        end
        checks++;
        if (borrow_out !== eb) begin
            errors++;
            $display("FAIL %s_borrow: got %b want %b", name, borrow_out, eb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({diff, borrow_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %0d/%b/%b/%b want 0/0/0/0",
                     diff, borrow_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_op(8'd10, 8'd3, 8'd7, 1'b0, "basic");
        do_op(8'd200, 8'd55, 8'd145, 1'b0, "basic2");
    endtask

    task automatic test_underflow();
`ifdef SERIAL_SUB_SAT_EN
        do_op(8'd3, 8'd10, 8'd0, 1'b1, "under");
`else
        do_op(8'd3, 8'd10, 8'd249, 1'b1, "under");
`endif
    endtask

    task automatic test_corners();
        do_op(8'd0, 8'd0, 8'd0, 1'b0, "zero");
        do_op(8'd255, 8'd255, 8'd0, 1'b0, "ones");
`ifdef SERIAL_SUB_SAT_EN
        do_op(8'd0, 8'd1, 8'd0, 1'b1, "wrap");
`else
        do_op(8'd0, 8'd1, 8'd255, 1'b1, "wrap");
`endif
    endtask

    task automatic test_start_busy();
        int seen;
        int lat;
        seen = 0;
        lat  = 0;
        @(negedge clk);
        a = 8'd50;
        b = 8'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (seen == 0) lat = n;
                seen++;
            end
            start = (n == 3);
            if (n == 3) begin
                a = 8'd1;
                b = 8'd2;
            end
        end
        checks++;
        if (seen != 1 || lat != W + 1) begin
            errors++;
            $display("FAIL busy_drop: pulses %0d at edge %0d want 1 at %0d",
                     seen, lat, W + 1);
        end
        checks++;
        if (diff !== 8'd30 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL busy_diff: got %0d/%b want 30/0", diff, borrow_out);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        a = 8'd100;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({diff, borrow_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %0d/%b/%b/%b want 0/0/0/0",
                     diff, borrow_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone: pulses %0d busy %b want 0/0", seen, busy);
        end
        do_op(8'd9, 8'd4, 8'd5, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] opa [3];
        logic [W-1:0] opb [3];
        logic [W-1:0] md;
        logic         mb;
        int           k;
        int           last;
        opa[0] = 8'd200; opb[0] = 8'd100;
        opa[1] = 8'd5;   opb[1] = 8'd6;
        opa[2] = 8'd128; opb[2] = 8'd127;
        k = 0;
        last = 0;
        @(negedge clk);
        a = opa[0];
        b = opb[0];
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 && k < 3) begin
                md = opa[k] - opb[k];
                mb = (opa[k] < opb[k]);
`ifdef SERIAL_SUB_SAT_EN
                if (mb) md = '0;
`endif
                checks++;
                if (n != (W + 1) + k * (W + 2)) begin
                    errors++;
                    $display("FAIL b2b_time%0d: edge %0d want %0d (prev %0d)",
                             k, n, (W + 1) + k * (W + 2), last);
                end
                checks++;
                if (diff !== md || borrow_out !== mb) begin
                    errors++;
                    $display("FAIL b2b_val%0d: got %0d/%b want %0d/%b",
                             k, diff, borrow_out, md, mb);
                end
                last = n;
                k++;
                if (k < 3) begin
                    a = opa[k];
                    b = opb[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses want 3", k);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_corners();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
